conway_nxm_serial: RTL and testbench
====================================

CONWAY_NXM_SERIAL -- requirements
Module: CONWAY_NXM_SERIAL

Interface
REQ-001 SHALL have parameter WIDTH, default 8, grid columns (>=3).
REQ-002 SHALL have parameter HEIGHT, default 8, grid rows (>=3); N = WIDTH*HEIGHT cells, cell index = row*WIDTH+col.
REQ-003 SHALL have parameter GEN_W, default 16, width of step and generation counters.
REQ-004 CLK  input  1  single system clock, all state on rising edge.
REQ-005 RESET  input  1  asynchronous, active-low reset.
REQ-006 CMD  input  2  command: 00 LOAD, 01 RUN, 10 DUMP, 11 CLEAR.
REQ-007 CMD_VALID  input  1  command request.
REQ-008 CMD_READY  output  1  high only in IDLE; command accepted on edge with CMD_VALID&&CMD_READY.
REQ-009 STEPS  input  GEN_W  generation budget for RUN, sampled at accept.
REQ-010 WRAP  input  1  1 = toroidal edges, 0 = dead border; sampled at accept, held for the command.
REQ-011 DATA_IN  input  1  serial grid bit.
REQ-012 DATA_IN_VALID  input  1  DATA_IN qualifier; ignored outside LOAD.
REQ-013 DATA_OUT  output  1  serial grid bit.
REQ-014 DATA_OUT_VALID  output  1  DATA_OUT qualifier.
REQ-015 BUSY  output  1  high in any non-IDLE state.
REQ-016 DONE  output  1  one-cycle pulse on the cycle the FSM re-enters IDLE.
REQ-017 GEN_COUNT  output  GEN_W  generations computed since last LOAD/CLEAR.
REQ-018 STABLE  output  1  last RUN ended because a generation produced no change.

Function
REQ-019 FSM states SHALL be IDLE, LOAD, RUN, DUMP, CLEAR; accept moves IDLE to the commanded state next cycle; CMD_VALID outside IDLE SHALL be ignored.
REQ-020 LOAD SHALL shift each DATA_IN_VALID bit into a shadow register, first bit landing at index N-1, last at index 0; bit counter counts 0..N-1.
REQ-021 On the Nth valid bit LOAD SHALL copy shadow to grid memory, clear GEN_COUNT and STABLE, and return to IDLE with DONE; the grid SHALL be untouched until then.
REQ-022 RUN SHALL compute one generation per cycle using B3/S23 over 8 neighbours; WRAP=0 treats out-of-grid neighbours as dead, WRAP=1 wraps rows and columns modulo HEIGHT/WIDTH.
REQ-023 RUN SHALL perform at most STEPS generations; each written generation increments GEN_COUNT, saturating at 2^GEN_W-1 (no wrap).
REQ-024 If a computed generation equals the current grid, RUN SHALL not write or count it, SHALL set STABLE, and SHALL exit to IDLE next cycle.
REQ-025 RUN with STEPS=0 SHALL spend one cycle in RUN, change nothing, and return to IDLE with DONE; STABLE SHALL clear on every RUN accept.
REQ-026 DUMP SHALL emit N bits on N consecutive cycles, index N-1 first, DATA_OUT_VALID high exactly those N cycles; grid unchanged; DUMP then returns to IDLE.
REQ-027 CLEAR SHALL zero grid, shadow, GEN_COUNT and STABLE in one cycle, then return to IDLE.
REQ-028 DATA_OUT SHALL be 0 whenever DATA_OUT_VALID is low.
REQ-029 Back-to-back commands SHALL be accepted on the DONE cycle (CMD_READY high with DONE).

Reset
REQ-030 RESET low SHALL immediately force IDLE, zero grid, shadow, counters, GEN_COUNT, STABLE, DONE, DATA_OUT, DATA_OUT_VALID, BUSY=0, CMD_READY=1.
REQ-031 Reset mid-LOAD, RUN or DUMP SHALL abandon the operation with no DONE pulse; release SHALL be taken synchronously so first accept occurs no earlier than the first edge after deassertion.

Verification
REQ-032 8x8, WRAP=0: LOAD horizontal blinker at (3,2..4), RUN STEPS=3 -> GEN_COUNT=3, DUMP shows vertical blinker at (2..4,3), STABLE=0.
REQ-033 LOAD 2x2 block at (1,1), RUN STEPS=100 -> DONE after 2 busy cycles, GEN_COUNT=0, STABLE=1, grid unchanged.
REQ-034 WRAP=1: glider RUN STEPS=32 -> grid equals initial glider pattern, GEN_COUNT=32; same with WRAP=0 -> grid differs (glider dies into border block).
REQ-035 Assert RESET low after 40 of 64 LOAD bits, release, DUMP -> 64 zero bits, DATA_OUT_VALID high exactly 64 cycles.
REQ-036 GEN_W=4: RUN blinker STEPS=15 twice -> GEN_COUNT saturates at 15; RUN STEPS=0 -> DONE one cycle after accept, grid unchanged.

Source files
------------

// File: rtl/conway_nxm_serial_if.sv
// ============================================================================
// Module : conway_nxm_serial_if
// Brief  : Command, serial data and status bundle for conway_nxm_serial.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface conway_nxm_serial_if #(
  parameter int GEN_W = 16
);
  logic [1:0]       cmd;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [GEN_W-1:0] steps;
  logic             wrap;
  logic             data_in;
  logic             data_in_valid;
  logic             data_out;
  logic             data_out_valid;
  logic             busy;
  logic             done;
  logic [GEN_W-1:0] gen_count;
  logic             stable;

  modport master (
    output cmd, cmd_valid, steps, wrap, data_in, data_in_valid,
    input  cmd_ready, data_out, data_out_valid, busy, done, gen_count, stable
  );

  modport slave (
    input  cmd, cmd_valid, steps, wrap, data_in, data_in_valid,
    output cmd_ready, data_out, data_out_valid, busy, done, gen_count, stable
  );
endinterface

`default_nettype wire

// File: rtl/conway_nxm_serial.sv
// ============================================================================
// Module : conway_nxm_serial
// Brief  : WIDTHxHEIGHT Game of Life engine (B3/S23), one generation per
//          cycle, with serial load/dump and a command handshake.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conway_nxm_serial #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  parameter int GEN_W  = 16
) (
  input  wire                  clk,
  input  wire                  rst_n,
  conway_nxm_serial_if.slave   bus
);

  localparam int N     = WIDTH * HEIGHT;
  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  localparam logic [1:0] CMD_LOAD  = 2'b00;
  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_DUMP  = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DUMP  = 3'd3,
    ST_CLEAR = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     grid_q, grid_d;
  logic [N-1:0]     shadow_q, shadow_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [GEN_W-1:0] steps_q, steps_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             wrap_q, wrap_d;
  logic             stable_q, stable_d;
  logic             stop_q, stop_d;
  logic             done_q, done_d;

  logic [N-1:0]     next_grid;
  logic [3:0]       nbrs;
  logic [IDX_W-1:0] dump_idx;

  function automatic logic [IDX_W-1:0] cell_idx(input int r, input int c);
    int k;
    k = r * WIDTH + c;
    return k[IDX_W-1:0];
  endfunction

  // Neighbour lookup: wrapped coordinates on a torus, otherwise dead outside.
  function automatic logic nb_alive(input logic [N-1:0] g, input int r,
                                    input int c, input logic wrap);
    logic alive;
    alive = 1'b0;
    if (wrap) begin
      alive = g[cell_idx((r + HEIGHT) % HEIGHT, (c + WIDTH) % WIDTH)];
    end else if (r >= 0 && r < HEIGHT && c >= 0 && c < WIDTH) begin
      alive = g[cell_idx(r, c)];
    end
    return alive;
  endfunction

  always_comb begin
    next_grid = '0;
    nbrs      = '0;
    for (int r = 0; r < HEIGHT; r++) begin
      for (int c = 0; c < WIDTH; c++) begin
        nbrs = '0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0) begin
              nbrs = nbrs + {3'b000, nb_alive(grid_q, r + dr, c + dc, wrap_q)};
            end
          end
        end
        if (grid_q[cell_idx(r, c)]) begin
          next_grid[cell_idx(r, c)] = (nbrs == 4'd2) || (nbrs == 4'd3);
        end else begin
          next_grid[cell_idx(r, c)] = (nbrs == 4'd3);
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grid_d   = grid_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    steps_d  = steps_q;
    gen_d    = gen_q;
    wrap_d   = wrap_q;
    stable_d = stable_q;
    stop_d   = stop_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          wrap_d = bus.wrap;
          cnt_d  = '0;
          case (bus.cmd)
            CMD_LOAD:  state_d = ST_LOAD;
            CMD_RUN: begin
              state_d  = ST_RUN;
              steps_d  = bus.steps;
              stable_d = 1'b0;
              stop_d   = 1'b0;
            end
            CMD_DUMP:  state_d = ST_DUMP;
            CMD_CLEAR: state_d = ST_CLEAR;
            default:   state_d = ST_IDLE;
          endcase
        end
      end

      ST_LOAD: begin
        if (bus.data_in_valid) begin
          shadow_d = {shadow_q[N-2:0], bus.data_in};
          if (cnt_q == LAST_IDX) begin
            grid_d   = {shadow_q[N-2:0], bus.data_in};
            gen_d    = '0;
            stable_d = 1'b0;
            cnt_d    = '0;
            state_d  = ST_IDLE;
            done_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      // A stable generation costs one extra RUN cycle so the exit is registered.
      ST_RUN: begin
        if (stop_q || steps_q == '0) begin
          stop_d  = 1'b0;
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (next_grid == grid_q) begin
          stable_d = 1'b1;
          stop_d   = 1'b1;
        end else begin
          grid_d  = next_grid;
          steps_d = steps_q - 1'b1;
          gen_d   = (gen_q == '1) ? gen_q : gen_q + 1'b1;
        end
      end

      ST_DUMP: begin
        if (cnt_q == LAST_IDX) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_CLEAR: begin
        grid_d   = '0;
        shadow_d = '0;
        gen_d    = '0;
        stable_d = 1'b0;
        state_d  = ST_IDLE;
        done_d   = 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grid_q   <= '0;
      shadow_q <= '0;
      cnt_q    <= '0;
      steps_q  <= '0;
      gen_q    <= '0;
      wrap_q   <= 1'b0;
      stable_q <= 1'b0;
      stop_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grid_q   <= grid_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      steps_q  <= steps_d;
      gen_q    <= gen_d;
      wrap_q   <= wrap_d;
      stable_q <= stable_d;
      stop_q   <= stop_d;
      done_q   <= done_d;
    end
  end

  assign dump_idx           = LAST_IDX - cnt_q;
  assign bus.cmd_ready      = (state_q == ST_IDLE);
  assign bus.busy           = (state_q != ST_IDLE);
  assign bus.done           = done_q;
  assign bus.gen_count      = gen_q;
  assign bus.stable         = stable_q;
  assign bus.data_out_valid = (state_q == ST_DUMP);
  assign bus.data_out       = (state_q == ST_DUMP) ? grid_q[dump_idx] : 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_conway_nxm_serial.sv
// ============================================================================
// Module : tb_conway_nxm_serial
// Brief  : Directed bench for conway_nxm_serial (8x8, GEN_W 16 and GEN_W 4).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conway_nxm_serial;

  localparam int N = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  cmd = 2'b00;
  logic        cmd_valid = 1'b0;
  logic [15:0] steps = '0;
  logic        wrap = 1'b0;
  logic        din = 1'b0;
  logic        din_valid = 1'b0;
  logic        sel_b = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  conway_nxm_serial_if #(.GEN_W(16)) bus_a ();
  conway_nxm_serial_if #(.GEN_W(4))  bus_b ();

  assign bus_a.cmd           = cmd;
  assign bus_a.cmd_valid     = cmd_valid & ~sel_b;
  assign bus_a.steps         = steps;
  assign bus_a.wrap          = wrap;
  assign bus_a.data_in       = din;
  assign bus_a.data_in_valid = din_valid;
  assign bus_b.cmd           = cmd;
  assign bus_b.cmd_valid     = cmd_valid & sel_b;
  assign bus_b.steps         = steps[3:0];
  assign bus_b.wrap          = wrap;
  assign bus_b.data_in       = din;
  assign bus_b.data_in_valid = din_valid;

  conway_nxm_serial #(.WIDTH(8), .HEIGHT(8), .GEN_W(16)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  conway_nxm_serial #(.WIDTH(8), .HEIGHT(8), .GEN_W(4)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  logic        obs_ready, obs_busy, obs_done, obs_dout, obs_dval, obs_stable;
  logic [15:0] obs_gen;
  assign obs_ready  = sel_b ? bus_b.cmd_ready      : bus_a.cmd_ready;
  assign obs_busy   = sel_b ? bus_b.busy           : bus_a.busy;
  assign obs_done   = sel_b ? bus_b.done           : bus_a.done;
  assign obs_dout   = sel_b ? bus_b.data_out       : bus_a.data_out;
  assign obs_dval   = sel_b ? bus_b.data_out_valid : bus_a.data_out_valid;
  assign obs_stable = sel_b ? bus_b.stable         : bus_a.stable;
  assign obs_gen    = sel_b ? {12'h000, bus_b.gen_count} : bus_a.gen_count;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] c, input logic [15:0] s, input logic w);
    int t;
    t = 0;
    while (!obs_ready && t < 200) begin
      step();
      t++;
    end
    if (!obs_ready) check_eq("cmd_ready_timeout", {63'd0, obs_ready}, 64'd1);
    cmd       = c;
    steps     = s;
    wrap      = w;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int busy_cyc);
    int t;
    t = 0;
    busy_cyc = 0;
    while (!obs_done && t < 500) begin
      if (obs_busy) busy_cyc++;
      step();
      t++;
    end
    check_eq("done_with_ready", {62'd0, obs_done, obs_ready}, 64'd3);
  endtask

  task automatic load_grid(input logic [63:0] g);
    int bc;
    send_cmd(2'b00, 16'd0, 1'b0);
    for (int i = N - 1; i >= 0; i--) begin
      din       = g[i];
      din_valid = 1'b1;
      step();
    end
    din_valid = 1'b0;
    din       = 1'b0;
    wait_done(bc);
  endtask

  task automatic run_gen(input logic [15:0] s, input logic w, output int bc);
    send_cmd(2'b01, s, w);
    wait_done(bc);
  endtask

  task automatic dump_grid(output logic [63:0] g, output int vcnt);
    int k;
    int t;
    int zero_bad;
    k = N - 1;
    t = 0;
    zero_bad = 0;
    g = '0;
    vcnt = 0;
    send_cmd(2'b10, 16'd0, 1'b0);
    while (!obs_done && t < 300) begin
      if (obs_dval) begin
        if (k >= 0) g[k] = obs_dout;
        k--;
        vcnt++;
      end else if (obs_dout) begin
        zero_bad++;
      end
      step();
      t++;
    end
    if (obs_dval || obs_dout) zero_bad++;
    check_eq("dump_done", {63'd0, obs_done}, 64'd1);
    check_eq("dout_idle_zero", 64'(zero_bad), 64'd0);
  endtask

  logic [63:0] blk_h, blk_v, block, glider, got;
  int          bc, vc;

  initial begin
    blk_h  = '0; blk_h[26] = 1'b1; blk_h[27] = 1'b1; blk_h[28] = 1'b1;
    blk_v  = '0; blk_v[19] = 1'b1; blk_v[27] = 1'b1; blk_v[35] = 1'b1;
    block  = '0; block[9]  = 1'b1; block[10] = 1'b1; block[17] = 1'b1; block[18] = 1'b1;
    glider = '0; glider[1] = 1'b1; glider[10] = 1'b1;
    glider[16] = 1'b1; glider[17] = 1'b1; glider[18] = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ready",  {63'd0, obs_ready}, 64'd1);
    check_eq("rst_busy",   {63'd0, obs_busy}, 64'd0);
    check_eq("rst_done",   {63'd0, obs_done}, 64'd0);
    check_eq("rst_dval",   {63'd0, obs_dval}, 64'd0);
    check_eq("rst_dout",   {63'd0, obs_dout}, 64'd0);
    check_eq("rst_gen",    {48'd0, obs_gen}, 64'd0);
    check_eq("rst_stable", {63'd0, obs_stable}, 64'd0);
    rst_n = 1'b1;
    step();

    // Blinker oscillates: three generations leave it vertical.
    load_grid(blk_h);
    run_gen(16'd3, 1'b0, bc);
    check_eq("blinker_busy", 64'(bc), 64'd4);
    check_eq("blinker_gen", {48'd0, obs_gen}, 64'd3);
    check_eq("blinker_stable", {63'd0, obs_stable}, 64'd0);
    dump_grid(got, vc);
    check_eq("blinker_grid", got, blk_v);
    check_eq("blinker_vcnt", 64'(vc), 64'd64);

    load_grid(block);
    check_eq("load_clears_gen", {48'd0, obs_gen}, 64'd0);
    run_gen(16'd100, 1'b0, bc);
    check_eq("block_busy", 64'(bc), 64'd2);
    check_eq("block_gen", {48'd0, obs_gen}, 64'd0);
    check_eq("block_stable", {63'd0, obs_stable}, 64'd1);
    dump_grid(got, vc);
    check_eq("block_grid", got, block);

    // 32 generations move a glider 8 cells diagonally: a full lap of the torus.
    load_grid(glider);
    run_gen(16'd32, 1'b1, bc);
    check_eq("glider_wrap_gen", {48'd0, obs_gen}, 64'd32);
    check_eq("glider_wrap_stable", {63'd0, obs_stable}, 64'd0);
    dump_grid(got, vc);
    check_eq("glider_wrap_grid", got, glider);

    load_grid(glider);
    run_gen(16'd32, 1'b0, bc);
    dump_grid(got, vc);
    check_eq("glider_border_differs", {63'd0, (got != glider)}, 64'd1);

    send_cmd(2'b11, 16'd0, 1'b0);
    wait_done(bc);
    check_eq("clear_busy", 64'(bc), 64'd1);
    check_eq("clear_gen", {48'd0, obs_gen}, 64'd0);
    check_eq("clear_stable", {63'd0, obs_stable}, 64'd0);
    dump_grid(got, vc);
    check_eq("clear_grid", got, 64'd0);

    // Reset part-way through a LOAD over a live grid.
    load_grid(blk_h);
    run_gen(16'd1, 1'b0, bc);
    check_eq("pre_reset_gen", {48'd0, obs_gen}, 64'd1);
    send_cmd(2'b00, 16'd0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      din       = 1'b1;
      din_valid = 1'b1;
      step();
    end
    rst_n = 1'b0;
    #1;
    check_eq("midload_rst_busy",  {63'd0, obs_busy}, 64'd0);
    check_eq("midload_rst_ready", {63'd0, obs_ready}, 64'd1);
    check_eq("midload_rst_gen",   {48'd0, obs_gen}, 64'd0);
    check_eq("midload_rst_done",  {63'd0, obs_done}, 64'd0);
    din_valid = 1'b0;
    din       = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    check_eq("post_rst_no_done", {62'd0, obs_done, obs_busy}, 64'd0);
    dump_grid(got, vc);
    check_eq("post_rst_grid", got, 64'd0);
    check_eq("post_rst_vcnt", 64'(vc), 64'd64);

    // Narrow counter instance: generation count saturates at 15.
    sel_b = 1'b1;
    load_grid(blk_h);
    run_gen(16'd15, 1'b0, bc);
    check_eq("sat_gen_first", {48'd0, obs_gen}, 64'd15);
    run_gen(16'd15, 1'b0, bc);
    check_eq("sat_gen_second", {48'd0, obs_gen}, 64'd15);
    dump_grid(got, vc);
    check_eq("sat_grid", got, blk_h);
    run_gen(16'd0, 1'b0, bc);
    check_eq("steps0_busy", 64'(bc), 64'd1);
    check_eq("steps0_gen", {48'd0, obs_gen}, 64'd15);
    dump_grid(got, vc);
    check_eq("steps0_grid", got, blk_h);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
